// File: rtl/tq_quant4x4.sv
// Forward 4x4 quantiser: |W|*MF + f, shifted by qbits, sign restored, two-stage pipe.
// QP is latched on beat 0 of each block; per-block non-zero count rides on the last level.

module tq_mod6 (
    input  logic [5:0] qp_i,
    output logic [2:0] mod_o
);
    always_comb mod_o = 3'(qp_i % 6'd6);
endmodule

module tq_quant4x4 #(
    parameter int COEF_W = 16,
    parameter int NZ_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        qp_i,
    input  logic              intra_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [COEF_W-1:0] coef_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [COEF_W-1:0] level_o,
    output logic [3:0]        idx_o,
    output logic              last_o,
    output logic [NZ_W-1:0]   nz_cnt_o
);
    localparam int MAG_W = COEF_W + 1;

    logic [3:0]        in_idx_q, in_idx_d;
    logic [5:0]        qp_lat_q, qp_lat_d;
    logic              intra_lat_q, intra_lat_d;
    logic [1:0]        vld_pipe_q, vld_pipe_d;   // [0] stage 1, [1] output
    logic [MAG_W-1:0]  s1_abs_q, s1_abs_d;
    logic              s1_neg_q, s1_neg_d;
    logic [13:0]       s1_mf_q, s1_mf_d;
    logic [31:0]       s1_f_q, s1_f_d;
    logic [4:0]        s1_qb_q, s1_qb_d;
    logic [3:0]        s1_idx_q, s1_idx_d;
    logic [COEF_W-1:0] level_q, level_d;
    logic [3:0]        idx_q, idx_d;
    logic              last_q, last_d;
    logic [NZ_W-1:0]   nz_out_q, nz_out_d;
    logic [NZ_W-1:0]   acc_q, acc_d;

    logic              en, acc_in;
    logic [5:0]        qp_eff;
    logic              intra_eff;
    logic [2:0]        mod;
    logic [3:0]        div;
    logic [4:0]        qbits;
    logic [31:0]       pow2;
    logic [13:0]       mf;
    logic [MAG_W-1:0]  w_ext;
    logic [31:0]       mag;
    logic [COEF_W-1:0] mag_w;
    logic              nz;

    assign en         = !vld_pipe_q[1] || out_ready_i;
    assign acc_in     = in_valid_i && en;
    assign in_ready_o = en;

    // Beat 0 sees the fresh QP; the rest of the block sees the latched copy.
    assign qp_eff    = (in_idx_q == 4'd0) ? ((qp_i > 6'd51) ? 6'd51 : qp_i) : qp_lat_q;
    assign intra_eff = (in_idx_q == 4'd0) ? intra_i : intra_lat_q;

    tq_mod6 u_mod6 (.qp_i(qp_eff), .mod_o(mod));

    always_comb begin
        div = 4'd0;
        for (int k = 1; k <= 8; k++)
            if (int'(qp_eff) >= 6 * k) div = 4'(k);
    end

    assign qbits = 5'd15 + {1'b0, div};
    assign pow2  = 32'd1 << qbits;

    always_comb begin
        logic a_cls, b_cls;
        a_cls = !in_idx_q[2] && !in_idx_q[0];
        b_cls =  in_idx_q[2] &&  in_idx_q[0];
        mf = 14'd0;
        case (mod)
            3'd0:    mf = a_cls ? 14'd13107 : b_cls ? 14'd5243 : 14'd8066;
            3'd1:    mf = a_cls ? 14'd11916 : b_cls ? 14'd4660 : 14'd7490;
            3'd2:    mf = a_cls ? 14'd10082 : b_cls ? 14'd4194 : 14'd6554;
            3'd3:    mf = a_cls ? 14'd9362  : b_cls ? 14'd3647 : 14'd5825;
            3'd4:    mf = a_cls ? 14'd8192  : b_cls ? 14'd3355 : 14'd5243;
            default: mf = a_cls ? 14'd7282  : b_cls ? 14'd2893 : 14'd4559;
        endcase
    end

    assign w_ext = {coef_i[COEF_W-1], coef_i};
    assign mag   = ((32'(s1_abs_q) * 32'(s1_mf_q)) + s1_f_q) >> s1_qb_q;
    assign mag_w = mag[COEF_W-1:0];
    assign nz    = (mag != 32'd0);

    always_comb begin
        in_idx_d    = in_idx_q;
        qp_lat_d    = qp_lat_q;
        intra_lat_d = intra_lat_q;
        vld_pipe_d  = vld_pipe_q;
        s1_abs_d    = s1_abs_q;
        s1_neg_d    = s1_neg_q;
        s1_mf_d     = s1_mf_q;
        s1_f_d      = s1_f_q;
        s1_qb_d     = s1_qb_q;
        s1_idx_d    = s1_idx_q;
        level_d     = level_q;
        idx_d       = idx_q;
        last_d      = last_q;
        nz_out_d    = nz_out_q;
        acc_d       = acc_q;
        if (acc_in) begin
            in_idx_d = in_idx_q + 4'd1;
            if (in_idx_q == 4'd0) begin
                qp_lat_d    = qp_eff;
                intra_lat_d = intra_i;
            end
        end
        if (en) begin
            vld_pipe_d = {vld_pipe_q[0], acc_in};
            if (acc_in) begin
                s1_abs_d = w_ext[MAG_W-1] ? -w_ext : w_ext;
                s1_neg_d = w_ext[MAG_W-1];
                s1_mf_d  = mf;
                s1_f_d   = intra_eff ? pow2 / 32'd3 : pow2 / 32'd6;
                s1_qb_d  = qbits;
                s1_idx_d = in_idx_q;
            end
            if (vld_pipe_q[0]) begin
                level_d = s1_neg_q ? -mag_w : mag_w;
                idx_d   = s1_idx_q;
                last_d  = (s1_idx_q == 4'd15);
                if (s1_idx_q == 4'd15) begin
                    nz_out_d = acc_q + NZ_W'(nz);
                    acc_d    = '0;
                end else begin
                    nz_out_d = '0;
                    acc_d    = acc_q + NZ_W'(nz);
                end
            end else begin
                last_d   = 1'b0;
                nz_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx_q    <= '0;
            qp_lat_q    <= '0;
            intra_lat_q <= 1'b0;
            vld_pipe_q  <= '0;
            s1_abs_q    <= '0;
            s1_neg_q    <= 1'b0;
            s1_mf_q     <= '0;
            s1_f_q      <= '0;
            s1_qb_q     <= '0;
            s1_idx_q    <= '0;
            level_q     <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            nz_out_q    <= '0;
            acc_q       <= '0;
        end else begin
            in_idx_q    <= in_idx_d;
            qp_lat_q    <= qp_lat_d;
            intra_lat_q <= intra_lat_d;
            vld_pipe_q  <= vld_pipe_d;
            s1_abs_q    <= s1_abs_d;
            s1_neg_q    <= s1_neg_d;
            s1_mf_q     <= s1_mf_d;
            s1_f_q      <= s1_f_d;
            s1_qb_q     <= s1_qb_d;
            s1_idx_q    <= s1_idx_d;
            level_q     <= level_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            nz_out_q    <= nz_out_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid_o = vld_pipe_q[1];
    assign level_o     = level_q;
    assign idx_o       = idx_q;
    assign last_o      = last_q;
    assign nz_cnt_o    = nz_out_q;
endmodule

// File: tb/tb_tq_quant4x4.sv
// Random and directed stimulus for tq_quant4x4 against a block-level arithmetic model.

module tb_tq_quant4x4;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  qp_i;
    logic        intra_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] coef_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] level_o;
    logic [3:0]  idx_o;
    logic        last_o;
    logic [4:0]  nz_cnt_o;

    always #5 clk = ~clk;

    tq_quant4x4 #(.COEF_W(16), .NZ_W(5)) dut (
        .clk(clk), .rst(rst), .qp_i(qp_i), .intra_i(intra_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .coef_i(coef_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .level_o(level_o),
        .idx_o(idx_o), .last_o(last_o), .nz_cnt_o(nz_cnt_o)
    );

    typedef struct { int qp; bit intra; int coef; } beat_t;
    typedef struct { int lvl; int idx; int last; int nz; int acyc; } exp_t;

    beat_t beatq[$];
    exp_t  expq[$];
    int    total = 0, bad = 0, cyc = 0;
    int    m_idx = 0, m_qp = 0, m_nz = 0;
    bit    m_intra = 0;
    bit    rdy_rand = 0, vld_rand = 0, lat_chk = 0, stall_arm = 0, hold_chk = 0;
    int    stall_cnt = 0, hold_lvl = 0, hold_idx = 0;
    int    c[16];
    int    got_lvl[16];
    int    got_nz = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Textbook H.264 forward quant: |W|*MF(qp%6,pos) + f, >> (15+qp/6).
    function automatic int ref_level(input int qp, input bit intra, input int idx, input int w);
        int mfa[6] = '{13107, 11916, 10082, 9362, 8192, 7282};
        int mfb[6] = '{5243, 4660, 4194, 3647, 3355, 2893};
        int mfc[6] = '{8066, 7490, 6554, 5825, 5243, 4559};
        int r, cc, mf, qb;
        longint a, f, m;
        r  = idx / 4;
        cc = idx % 4;
        if (r % 2 == 0 && cc % 2 == 0)      mf = mfa[qp % 6];
        else if (r % 2 == 1 && cc % 2 == 1) mf = mfb[qp % 6];
        else                                mf = mfc[qp % 6];
        qb = 15 + qp / 6;
        f  = (longint'(1) << qb) / (intra ? 3 : 6);
        a  = (w < 0) ? -longint'(w) : longint'(w);
        m  = (a * mf + f) >> qb;
        return (w < 0) ? -int'(m) : int'(m);
    endfunction

    task automatic model_accept();
        exp_t e;
        if (m_idx == 0) begin
            m_qp    = (int'(qp_i) > 51) ? 51 : int'(qp_i);
            m_intra = intra_i;
        end
        e.lvl  = ref_level(m_qp, m_intra, m_idx, int'($signed(coef_i)));
        e.idx  = m_idx;
        e.acyc = cyc;
        if (e.lvl != 0) m_nz++;
        e.last = (m_idx == 15);
        e.nz   = e.last ? m_nz : 0;
        if (e.last) m_nz = 0;
        m_idx = (m_idx + 1) % 16;
        expq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (stall_cnt > 0) begin out_ready_i = 1'b0; stall_cnt--; end
        else if (rdy_rand) out_ready_i = ($urandom_range(0, 3) != 0);
        else out_ready_i = 1'b1;
        if (beatq.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
            in_valid_i = 1'b1;
            qp_i    = 6'(beatq[0].qp);
            intra_i = beatq[0].intra;
            coef_i  = 16'(beatq[0].coef);
        end else begin
            in_valid_i = 1'b0;
            qp_i    = 6'($urandom);
            intra_i = 1'($urandom);
            coef_i  = 16'($urandom);
        end
        #1;
        if (hold_chk) begin
            chk("hold_valid", int'(out_valid_o), 1);
            chk("hold_level", int'($signed(level_o)), hold_lvl);
            chk("hold_idx", int'(idx_o), hold_idx);
        end
        hold_chk = out_valid_o && !out_ready_i;
        hold_lvl = int'($signed(level_o));
        hold_idx = int'(idx_o);
        if (out_valid_o && !out_ready_i) chk("stall_in_ready", int'(in_ready_o), 0);
        if (out_valid_o && out_ready_i) begin
            if (expq.size() == 0) chk("unexpected_out", expq.size(), 1);
            else begin
                e = expq.pop_front();
                chk("level", int'($signed(level_o)), e.lvl);
                chk("idx", int'(idx_o), e.idx);
                chk("last", int'(last_o), e.last);
                chk("nz_cnt", int'(nz_cnt_o), e.nz);
                if (lat_chk) chk("latency", cyc - e.acyc, 2);
                got_lvl[idx_o] = int'($signed(level_o));
                if (last_o) got_nz = int'(nz_cnt_o);
            end
        end
        if (in_valid_i && in_ready_o) begin
            model_accept();
            void'(beatq.pop_front());
        end
        if (stall_arm && m_idx == 6) begin
            stall_cnt = 5;
            stall_arm = 0;
        end
    endtask

    task automatic push_blk(input int qa, input int qb, input int chg, input bit intra, input bit scr);
        beat_t b;
        for (int i = 0; i < 16; i++) begin
            b.qp    = (i < chg) ? qa : qb;
            b.intra = (i > 0 && scr) ? 1'($urandom) : intra;
            b.coef  = c[i];
            beatq.push_back(b);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((beatq.size() > 0 || expq.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_timeout", beatq.size() + expq.size(), 0);
    endtask

    task automatic clr_c();
        for (int i = 0; i < 16; i++) c[i] = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(out_valid_o), 0);
        chk({tag, "_level"}, int'(level_o), 0);
        chk({tag, "_idx"}, int'(idx_o), 0);
        chk({tag, "_last"}, int'(last_o), 0);
        chk({tag, "_nz"}, int'(nz_cnt_o), 0);
        chk({tag, "_in_ready"}, int'(in_ready_o), 1);
    endtask

    initial begin
        rst = 1'b1; qp_i = '0; intra_i = 1'b0; in_valid_i = 1'b0;
        coef_i = '0; out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("rst0");
        rst = 1'b0;

        // qp 28 intra, unstalled: latency and basic levels
        lat_chk = 1;
        clr_c(); c[0] = 100; c[1] = -100; c[5] = 1000;
        push_blk(28, 28, 16, 1'b1, 1'b0); drain();
        chk("tp_q28_i0", got_lvl[0], 1);
        chk("tp_q28_i1", got_lvl[1], -1);
        chk("tp_q28_i5", got_lvl[5], 6);

        // qp 0 intra, extreme coefficients in back-to-back blocks
        clr_c(); c[0] = 32767;  push_blk(0, 0, 16, 1'b1, 1'b0);
        drain(); chk("tp_q0_max", got_lvl[0], 13106);
        clr_c(); c[0] = -32768; push_blk(0, 0, 16, 1'b1, 1'b0);
        drain(); chk("tp_q0_min", got_lvl[0], -13107);

        // qp 28 inter, three non-zero levels
        clr_c(); c[0] = 100; c[2] = 100; c[8] = 100; c[10] = 50;
        push_blk(28, 28, 16, 1'b0, 1'b0); drain();
        chk("tp_inter_100", got_lvl[0], 1);
        chk("tp_inter_50", got_lvl[10], 0);
        chk("tp_inter_nz", got_nz, 3);

        // qp_i moves to 0 from beat 7: latched 28 must persist
        for (int i = 0; i < 16; i++) c[i] = 1000;
        push_blk(28, 0, 7, 1'b1, 1'b0); drain();
        chk("tp_qpchg_7", got_lvl[7], 6);
        chk("tp_qpchg_15", got_lvl[15], 6);

        // qp 60 clamps to 51
        clr_c(); c[0] = 32767; c[1] = -32768;
        push_blk(60, 60, 16, 1'b1, 1'b0); drain();
        chk("tp_clamp_0", got_lvl[0], 36);
        chk("tp_clamp_1", got_lvl[1], -23);
        lat_chk = 0;

        // five-cycle downstream stall mid-block
        for (int i = 0; i < 16; i++) c[i] = int'($signed(16'($urandom)));
        stall_arm = 1;
        push_blk(20, 20, 16, 1'b1, 1'b0); drain();

        // asynchronous reset after nine beats
        for (int i = 0; i < 16; i++) c[i] = 100;
        push_blk(28, 28, 16, 1'b1, 1'b0);
        for (int n = 0; n < 200 && m_idx != 9; n++) step();
        chk("rst_reach9", m_idx, 9);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        in_valid_i = 1'b0;
        beatq.delete(); expq.delete();
        m_idx = 0; m_nz = 0; hold_chk = 0; stall_cnt = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        clr_c(); c[0] = 32767; c[3] = 100;
        push_blk(0, 0, 16, 1'b1, 1'b0); drain();
        chk("post_rst_lvl", got_lvl[0], 13106);
        chk("post_rst_nz", got_nz, 2);

        // random back-to-back blocks with random handshakes
        rdy_rand = 1; vld_rand = 1;
        for (int blk = 0; blk < 40; blk++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 3))
                    0: c[i] = 0;
                    1: c[i] = int'($urandom_range(0, 400)) - 200;
                    2: c[i] = int'($signed(16'($urandom)));
                    default: c[i] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                endcase
            end
            push_blk(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1,
                     1'($urandom), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
